// File: rtl/alu_iter.sv
// alu_iter: multi-cycle ALU with a single-cycle path for add/sub/logic ops
// and an iterative path (one bit per cycle) for multiply, divide and modulo.
//
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   start           request, sampled only while idle
//   op              opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOTA,
//                   6 MULLO, 7 MULHI, 8 DIV, 9 MOD, 10-15 reserved
//   a, b            operands, latched on the accept edge
//   signed_en       two's-complement mode for MUL/DIV/MOD
//   use_carry       enables carryin on ADD/SUB
//   carryin         carry-in value
//   busy            high whenever the FSM is not idle
//   done            one-cycle pulse when result/flags have been updated
//   result          registered result, held until the next done
//   carryout, overout, zero, neg, div_by_zero   registered flags
module alu_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_en,
    input  logic             use_carry,
    input  logic             carryin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overout,
    output logic             zero,
    output logic             neg,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] SMIN      = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] { IDLE, EXEC, ITER, FINAL } state_e;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_NOTA  = 4'd5,
        OP_MULLO = 4'd6,
        OP_MULHI = 4'd7,
        OP_DIV   = 4'd8,
        OP_MOD   = 4'd9
    } op_e;

    state_e state, state_nxt;
    logic [CW-1:0] cnt;

    // operands captured on the accept edge
    logic [3:0]       op_r;
    logic [WIDTH-1:0] a_r, b_r;
    logic             sgn_r, uc_r, ci_r;

    // iterative datapath
    logic [2*WIDTH-1:0] acc, mcand;
    logic [WIDTH-1:0]   mplier, rem, quo, dvsr;

    logic             a_neg, b_neg, is_mul, is_iter;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             fits;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo_s, rem_s;
    logic               mul_ovf, min_neg1;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res_nxt;
    logic             cout_nxt, ovf_nxt, dbz_nxt, commit;

    assign a_neg   = sgn_r & a_r[WIDTH-1];
    assign b_neg   = sgn_r & b_r[WIDTH-1];
    assign mag_a   = a_neg ? -a_r : a_r;
    assign mag_b   = b_neg ? -b_r : b_r;
    assign is_mul  = (op_r == OP_MULLO) || (op_r == OP_MULHI);
    assign is_iter = is_mul || (op_r == OP_DIV) || (op_r == OP_MOD);

    // Restoring-division trial subtract; a clear top pair means no underflow.
    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = {1'b0, shifted} - {2'b00, dvsr};
    assign fits    = (diff[WIDTH+1:WIDTH] == 2'b00);

    // Sign fix-up applied after the magnitude iterations.
    assign prod     = (a_neg ^ b_neg) ? -acc : acc;
    assign quo_s    = (a_neg ^ b_neg) ? -quo : quo;
    assign rem_s    = a_neg ? -rem : rem;
    assign mul_ovf  = sgn_r ? ~((&prod[2*WIDTH-1:WIDTH-1]) | ~(|prod[2*WIDTH-1:WIDTH-1]))
                            : (|prod[2*WIDTH-1:WIDTH]);
    assign min_neg1 = sgn_r && (a_r == SMIN) && (b_r == '1);

    assign commit = ((state == EXEC) && !is_iter) || (state == FINAL);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = EXEC;
            EXEC:    state_nxt = is_iter ? ITER : IDLE;
            ITER:    if (cnt == LAST_ITER) state_nxt = FINAL;
            FINAL:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state != IDLE);
    end

    // ---------------- operand capture and iteration ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            sgn_r  <= 1'b0;
            uc_r   <= 1'b0;
            ci_r   <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r  <= op;
                        a_r   <= a;
                        b_r   <= b;
                        sgn_r <= signed_en;
                        uc_r  <= use_carry;
                        ci_r  <= carryin;
                    end
                end
                EXEC: begin
                    cnt    <= '0;
                    acc    <= '0;
                    mcand  <= {{WIDTH{1'b0}}, mag_a};
                    mplier <= mag_b;
                    rem    <= '0;
                    quo    <= mag_a;
                    dvsr   <= mag_b;
                end
                ITER: begin
                    cnt <= cnt + CW'(1);
                    if (is_mul) begin
                        if (mplier[0]) acc <= acc + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end else if (fits) begin
                        rem <= diff[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= shifted[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- result selection ----------------
    always_comb begin
        sum      = '0;
        res_nxt  = '0;
        cout_nxt = 1'b0;
        ovf_nxt  = 1'b0;
        dbz_nxt  = 1'b0;
        if (state == EXEC) begin
            case (op_r)
                OP_ADD: begin
                    sum      = {1'b0, a_r} + {1'b0, b_r} + {{WIDTH{1'b0}}, uc_r & ci_r};
                    res_nxt  = sum[WIDTH-1:0];
                    cout_nxt = sum[WIDTH];
                    ovf_nxt  = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum[WIDTH-1] != a_r[WIDTH-1]);
                end
                OP_SUB: begin
                    sum      = {1'b0, a_r} + {1'b0, ~b_r} + {{WIDTH{1'b0}}, (uc_r ? ci_r : 1'b1)};
                    res_nxt  = sum[WIDTH-1:0];
                    cout_nxt = sum[WIDTH];
                    ovf_nxt  = (a_r[WIDTH-1] == ~b_r[WIDTH-1]) && (sum[WIDTH-1] != a_r[WIDTH-1]);
                end
                OP_AND:  res_nxt = a_r & b_r;
                OP_OR:   res_nxt = a_r | b_r;
                OP_XOR:  res_nxt = a_r ^ b_r;
                OP_NOTA: res_nxt = ~a_r;
                default: ;
            endcase
        end else if (state == FINAL) begin
            case (op_r)
                OP_MULLO: begin
                    res_nxt = prod[WIDTH-1:0];
                    ovf_nxt = mul_ovf;
                end
                OP_MULHI: begin
                    res_nxt = prod[2*WIDTH-1:WIDTH];
                    ovf_nxt = mul_ovf;
                end
                OP_DIV: begin
                    if (b_r == '0) begin
                        res_nxt = '1;
                        dbz_nxt = 1'b1;
                    end else begin
                        // MIN/-1 negates back to MIN naturally; only the flag is extra
                        res_nxt = quo_s;
                        ovf_nxt = min_neg1;
                    end
                end
                OP_MOD: begin
                    if (b_r == '0) begin
                        res_nxt = a_r;
                        dbz_nxt = 1'b1;
                    end else begin
                        res_nxt = rem_s;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- registered outputs ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done        <= 1'b0;
            result      <= '0;
            carryout    <= 1'b0;
            overout     <= 1'b0;
            zero        <= 1'b0;
            neg         <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= commit;
            if (commit) begin
                result      <= res_nxt;
                carryout    <= cout_nxt;
                overout     <= ovf_nxt;
                zero        <= (res_nxt == '0);
                neg         <= res_nxt[WIDTH-1];
                div_by_zero <= dbz_nxt;
            end
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: self-checking bench for alu_iter at WIDTH=8. Expected results
// come from an integer-arithmetic reference model and are queued when a
// request is driven, then popped and compared when done is seen.
module tb_alu_iter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         signed_en = 1'b0;
    logic         use_carry = 1'b0;
    logic         carryin = 1'b0;
    logic         busy, done, carryout, overout, zero, neg, div_by_zero;
    logic [W-1:0] result;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [7:0] res;
        logic       cout;
        logic       ovf;
        logic       zro;
        logic       ng;
        logic       dbz;
    } exp_t;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic       uc;
        logic       ci;
    } stim_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    alu_iter #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .op(op),
        .a(a),
        .b(b),
        .signed_en(signed_en),
        .use_carry(use_carry),
        .carryin(carryin),
        .busy(busy),
        .done(done),
        .result(result),
        .carryout(carryout),
        .overout(overout),
        .zero(zero),
        .neg(neg),
        .div_by_zero(div_by_zero)
    );

    // Reference model in plain integer arithmetic.
    function automatic exp_t model(input stim_t t);
        exp_t e;
        int ua, ub, sa, sb, as_, bs_, tmp, st, borrow, p, q, r;
        e   = '0;
        ua  = int'(t.a);
        ub  = int'(t.b);
        as_ = int'($signed(t.a));
        bs_ = int'($signed(t.b));
        sa  = t.s ? as_ : ua;
        sb  = t.s ? bs_ : ub;
        case (t.op)
            4'd0: begin
                tmp    = ua + ub + ((t.uc && t.ci) ? 1 : 0);
                st     = as_ + bs_ + ((t.uc && t.ci) ? 1 : 0);
                e.res  = tmp[7:0];
                e.cout = (tmp > 255);
                e.ovf  = (st > 127) || (st < -128);
            end
            4'd1: begin
                borrow = (t.uc && !t.ci) ? 1 : 0;
                tmp    = ua - ub - borrow;
                st     = as_ - bs_ - borrow;
                e.res  = tmp[7:0];
                e.cout = (ua >= ub + borrow);
                e.ovf  = (st > 127) || (st < -128);
            end
            4'd2: e.res = t.a & t.b;
            4'd3: e.res = t.a | t.b;
            4'd4: e.res = t.a ^ t.b;
            4'd5: e.res = ~t.a;
            4'd6, 4'd7: begin
                p     = sa * sb;
                e.res = (t.op == 4'd6) ? p[7:0] : p[15:8];
                e.ovf = t.s ? ((p > 127) || (p < -128)) : (p > 255);
            end
            4'd8, 4'd9: begin
                if (t.b == 8'h00) begin
                    e.res = (t.op == 4'd8) ? 8'hFF : t.a;
                    e.dbz = 1'b1;
                end else if (t.s && sa == -128 && sb == -1) begin
                    e.res = (t.op == 4'd8) ? 8'h80 : 8'h00;
                    e.ovf = (t.op == 4'd8);
                end else begin
                    q     = sa / sb;
                    r     = sa % sb;
                    e.res = (t.op == 4'd8) ? q[7:0] : r[7:0];
                end
            end
            default: e.res = 8'h00;
        endcase
        e.zro = (e.res == 8'h00);
        e.ng  = e.res[7];
        return e;
    endfunction

    function automatic int exp_lat(input stim_t t);
        return (t.op >= 4'd6 && t.op <= 4'd9) ? W + 2 : 1;
    endfunction

    function automatic exp_t observe();
        return {result, carryout, overout, zero, neg, div_by_zero};
    endfunction

    // Drive one request, queue its expectation, then scramble the inputs
    // after the accept edge so any late sampling shows up as a wrong result.
    task automatic issue(input stim_t t);
        @(negedge clk);
        op        = t.op;
        a         = t.a;
        b         = t.b;
        signed_en = t.s;
        use_carry = t.uc;
        carryin   = t.ci;
        start     = 1'b1;
        sbq.push_back(model(t));
        @(posedge clk);
        #1;
        start     = 1'b0;
        op        = 4'($urandom);
        a         = 8'($urandom);
        b         = 8'($urandom);
        signed_en = 1'($urandom);
        use_carry = 1'($urandom);
        carryin   = 1'($urandom);
    endtask

    // Called 1 time unit after the accept edge; counts edges until done.
    task automatic wait_done(output int lat, output bit bsy_ok, output bit to);
        lat    = 0;
        to     = 1'b0;
        bsy_ok = (busy === 1'b1);
        forever begin
            @(posedge clk);
            #1;
            lat++;
            if (done === 1'b1) break;
            if (busy !== 1'b1) bsy_ok = 1'b0;
            if (lat >= 40) begin
                to = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({busy, done, result, carryout, overout, zero, neg, div_by_zero} !== '0)
            $display("FAIL reset_outputs: got busy=%b done=%b result=%h flags=%b%b%b%b%b want all 0",
                     busy, done, result, carryout, overout, zero, neg, div_by_zero);
        else passed++;
        #1 rst_n = 1'b1;
    endtask

    task automatic test_add_sub();
        stim_t tbl [6] = '{
            {4'd0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0},
            {4'd0, 8'h7F, 8'h00, 1'b0, 1'b1, 1'b1},
            {4'd0, 8'h40, 8'h30, 1'b0, 1'b0, 1'b1},
            {4'd1, 8'h80, 8'h01, 1'b0, 1'b0, 1'b0},
            {4'd1, 8'h05, 8'h03, 1'b0, 1'b1, 1'b0},
            {4'd1, 8'h03, 8'h05, 1'b0, 1'b0, 1'b0}
        };
        int lat; bit bok, to; exp_t e, g;
        foreach (tbl[i]) begin
            issue(tbl[i]);
            wait_done(lat, bok, to);
            total++;
            if (to || lat != 1) $display("FAIL addsub_latency[%0d]: got %0d want 1", i, lat);
            else passed++;
            e = sbq.pop_front();
            g = observe();
            total++;
            if (g !== e)
                $display("FAIL addsub_result[%0d]: res/c/v/z/n/dz got %h/%b%b%b%b%b want %h/%b%b%b%b%b",
                         i, g.res, g.cout, g.ovf, g.zro, g.ng, g.dbz, e.res, e.cout, e.ovf, e.zro, e.ng, e.dbz);
            else passed++;
        end
    endtask

    task automatic test_logic();
        stim_t tbl [6] = '{
            {4'd2, 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b0},
            {4'd3, 8'hF0, 8'h0F, 1'b0, 1'b0, 1'b0},
            {4'd4, 8'hAA, 8'hAA, 1'b0, 1'b1, 1'b1},
            {4'd5, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0},
            {4'd12, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1},
            {4'd15, 8'h80, 8'h7F, 1'b0, 1'b0, 1'b0}
        };
        int lat; bit bok, to; exp_t e, g;
        foreach (tbl[i]) begin
            issue(tbl[i]);
            wait_done(lat, bok, to);
            total++;
            if (to || lat != 1) $display("FAIL logic_latency[%0d]: got %0d want 1", i, lat);
            else passed++;
            e = sbq.pop_front();
            g = observe();
            total++;
            if (g !== e)
                $display("FAIL logic_result[%0d]: res/c/v/z/n/dz got %h/%b%b%b%b%b want %h/%b%b%b%b%b",
                         i, g.res, g.cout, g.ovf, g.zro, g.ng, g.dbz, e.res, e.cout, e.ovf, e.zro, e.ng, e.dbz);
            else passed++;
        end
    endtask

    task automatic test_mul();
        stim_t tbl [4] = '{
            {4'd7, 8'hFE, 8'h03, 1'b1, 1'b0, 1'b0},
            {4'd6, 8'h0F, 8'h0D, 1'b0, 1'b0, 1'b0},
            {4'd7, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0},
            {4'd6, 8'h80, 8'hFF, 1'b1, 1'b0, 1'b0}
        };
        int lat; bit bok, to; exp_t e, g;
        foreach (tbl[i]) begin
            issue(tbl[i]);
            wait_done(lat, bok, to);
            total++;
            if (to || lat != exp_lat(tbl[i]))
                $display("FAIL mul_latency[%0d]: got %0d want %0d", i, lat, exp_lat(tbl[i]));
            else passed++;
            total++;
            if (!bok) $display("FAIL mul_busy[%0d]: busy dropped before done, want high throughout", i);
            else passed++;
            e = sbq.pop_front();
            g = observe();
            total++;
            if (g !== e)
                $display("FAIL mul_result[%0d]: res/c/v/z/n/dz got %h/%b%b%b%b%b want %h/%b%b%b%b%b",
                         i, g.res, g.cout, g.ovf, g.zro, g.ng, g.dbz, e.res, e.cout, e.ovf, e.zro, e.ng, e.dbz);
            else passed++;
        end
    endtask

    task automatic test_div();
        stim_t tbl [10] = '{
            {4'd8, 8'hF9, 8'h02, 1'b1, 1'b0, 1'b0},
            {4'd9, 8'hF9, 8'h02, 1'b1, 1'b0, 1'b0},
            {4'd8, 8'hC8, 8'h07, 1'b0, 1'b0, 1'b0},
            {4'd9, 8'hC8, 8'h07, 1'b0, 1'b0, 1'b0},
            {4'd8, 8'h07, 8'hFE, 1'b1, 1'b0, 1'b0},
            {4'd9, 8'h07, 8'hFE, 1'b1, 1'b0, 1'b0},
            {4'd8, 8'h80, 8'hFF, 1'b1, 1'b0, 1'b0},
            {4'd9, 8'h80, 8'hFF, 1'b1, 1'b0, 1'b0},
            {4'd8, 8'h2A, 8'h00, 1'b0, 1'b0, 1'b0},
            {4'd9, 8'hF0, 8'h00, 1'b1, 1'b0, 1'b0}
        };
        int lat; bit bok, to; exp_t e, g;
        foreach (tbl[i]) begin
            issue(tbl[i]);
            wait_done(lat, bok, to);
            total++;
            if (to || lat != exp_lat(tbl[i]))
                $display("FAIL div_latency[%0d]: got %0d want %0d", i, lat, exp_lat(tbl[i]));
            else passed++;
            e = sbq.pop_front();
            g = observe();
            total++;
            if (g !== e)
                $display("FAIL div_result[%0d]: res/c/v/z/n/dz got %h/%b%b%b%b%b want %h/%b%b%b%b%b",
                         i, g.res, g.cout, g.ovf, g.zro, g.ng, g.dbz, e.res, e.cout, e.ovf, e.zro, e.ng, e.dbz);
            else passed++;
        end
    endtask

    task automatic test_div_zero();
        stim_t tbl [3] = '{
            {4'd8, 8'h2A, 8'h00, 1'b0, 1'b0, 1'b0},
            {4'd9, 8'h2A, 8'h00, 1'b0, 1'b0, 1'b0},
            {4'd8, 8'hF0, 8'h00, 1'b1, 1'b0, 1'b0}
        };
        int lat; bit bok, to; exp_t e, g;
        foreach (tbl[i]) begin
            issue(tbl[i]);
            wait_done(lat, bok, to);
            total++;
            if (to || lat != W + 2) $display("FAIL divzero_latency[%0d]: got %0d want %0d", i, lat, W + 2);
            else passed++;
            e = sbq.pop_front();
            g = observe();
            total++;
            if (g !== e)
                $display("FAIL divzero_result[%0d]: res/c/v/z/n/dz got %h/%b%b%b%b%b want %h/%b%b%b%b%b",
                         i, g.res, g.cout, g.ovf, g.zro, g.ng, g.dbz, e.res, e.cout, e.ovf, e.zro, e.ng, e.dbz);
            else passed++;
        end
    endtask

    task automatic test_start_ignored();
        stim_t t = {4'd6, 8'h10, 8'h10, 1'b0, 1'b0, 1'b0};
        int lat, nd; bit bok, to; exp_t e, g;
        issue(t);
        fork
            wait_done(lat, bok, to);
            begin
                repeat (3) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        total++;
        if (to || lat != W + 2) $display("FAIL ignored_latency: got %0d want %0d", lat, W + 2);
        else passed++;
        e = sbq.pop_front();
        g = observe();
        total++;
        if (g !== e)
            $display("FAIL ignored_result: res/c/v/z/n/dz got %h/%b%b%b%b%b want %h/%b%b%b%b%b",
                     g.res, g.cout, g.ovf, g.zro, g.ng, g.dbz, e.res, e.cout, e.ovf, e.zro, e.ng, e.dbz);
        else passed++;
        nd = 0;
        repeat (14) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) nd++;
        end
        total++;
        if (nd != 0) $display("FAIL ignored_no_queue: got %0d busy/done cycles want 0", nd);
        else passed++;
    endtask

    task automatic test_back_to_back();
        stim_t t1 = {4'd0, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0};
        stim_t t2 = {4'd1, 8'h50, 8'h20, 1'b0, 1'b0, 1'b0};
        int lat; bit bok, to; exp_t e, g;
        issue(t1);
        wait_done(lat, bok, to);
        e = sbq.pop_front();
        g = observe();
        total++;
        if (to || g !== e) $display("FAIL b2b_first: res got %h want %h (timeout=%b)", g.res, e.res, to);
        else passed++;
        issue(t2);
        total++;
        if (done !== 1'b0) $display("FAIL b2b_done_pulse: got done=%b want 0", done);
        else passed++;
        wait_done(lat, bok, to);
        total++;
        if (to || lat != 1) $display("FAIL b2b_latency: got %0d want 1", lat);
        else passed++;
        e = sbq.pop_front();
        g = observe();
        total++;
        if (g !== e) $display("FAIL b2b_second: res got %h want %h", g.res, e.res);
        else passed++;
        repeat (3) @(posedge clk);
        #1;
        g = observe();
        total++;
        if (g !== e) $display("FAIL b2b_hold: got %h want %h", g, e);
        else passed++;
    endtask

    task automatic test_abort();
        stim_t t = {4'd0, 8'h05, 8'h03, 1'b0, 1'b0, 1'b0};
        int lat, nd; bit bok, to; exp_t e, g;
        @(negedge clk);
        op = 4'd6; a = 8'h10; b = 8'h10;
        signed_en = 1'b0; use_carry = 1'b0; carryin = 1'b0;
        start = 1'b1;
        @(posedge clk);             // accept edge, cycle 0
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;               // sampled at edge 2, during ITER
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);             // edge 3
        @(posedge clk);             // edge 4
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, result, carryout, overout, zero, neg, div_by_zero} !== '0)
            $display("FAIL abort_outputs: got busy=%b done=%b result=%h flags=%b%b%b%b%b want all 0",
                     busy, done, result, carryout, overout, zero, neg, div_by_zero);
        else passed++;
        nd = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) nd++;
        end
        total++;
        if (nd != 0) $display("FAIL abort_hold: got %0d busy/done cycles in reset want 0", nd);
        else passed++;
        @(posedge clk);
        #2 rst_n = 1'b1;
        issue(t);
        wait_done(lat, bok, to);
        total++;
        if (to || lat != 1) $display("FAIL abort_fresh_latency: got %0d want 1", lat);
        else passed++;
        e = sbq.pop_front();
        g = observe();
        total++;
        if (g !== e) $display("FAIL abort_fresh_result: got %h want %h", g, e);
        else passed++;
        nd = 0;
        repeat (14) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) nd++;
        end
        total++;
        if (nd != 0) $display("FAIL abort_no_done: got %0d stray done pulses want 0", nd);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_logic();
        test_mul();
        test_div();
        test_div_zero();
        test_start_ignored();
        test_back_to_back();
        test_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, total);
        $fatal(1);
    end

endmodule
